aes_round_sched: RTL and testbench

//  Sequencer for the AES-128 encrypt path. Accepts a block request (optionally with a new key),

---
 rtl/aes_round_sched.sv | 134 +++++++++++++
 tb/tb_aes_round_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sched.sv
// AES-128 encrypt round sequencer.
// Takes a block request, runs key expansion when the cached key is missing or
// replaced, then steps the round datapath through the initial AddRoundKey and
// rounds 1..NUM_ROUNDS before presenting the result on a valid/ready handshake.
module aes_round_sched #(
   parameter int NUM_ROUNDS = 10,
   parameter int KE_TIMEOUT = 31
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_new_key,
   input  logic [127:0] in_key,
   output logic         ke_en,
   output logic [127:0] ke_key,
   input  logic         ke_done,
   output logic [3:0]   round,
   output logic         dp_load,
   output logic         dp_init,
   output logic         dp_step,
   output logic         dp_final,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         key_err
);

   localparam int CW = $clog2(KE_TIMEOUT + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_KEXP = 3'd1;
   localparam logic [2:0] S_INIT = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]    state;
   logic          key_valid;
   logic          key_err_q;
   logic [127:0]  ke_key_q;
   logic [3:0]    round_q;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          last_round;

   // cnt holds the number of KEXP cycles already completed, so cnt_nxt is the
   // count including the current one; abort when that reaches the limit.
   assign cnt_nxt    = cnt + 1'b1;
   assign last_round = (round_q == 4'(NUM_ROUNDS));

   // Sequencer state, key cache and round counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         key_valid <= 1'b0;
         key_err_q <= 1'b0;
         ke_key_q  <= '0;
         round_q   <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (in_new_key || !key_valid) begin
                     ke_key_q  <= in_key;
                     key_valid <= 1'b0;
                     key_err_q <= 1'b0;
                     cnt       <= '0;
                     state     <= S_KEXP;
                  end else begin
                     state <= S_INIT;
                  end
               end
            end
            S_KEXP: begin
               cnt <= cnt_nxt;
               // A completion on the final allowed cycle still counts as success.
               if (ke_done) begin
                  key_valid <= 1'b1;
                  state     <= S_INIT;
               end else if (cnt_nxt == CW'(KE_TIMEOUT)) begin
                  key_err_q <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            S_INIT: begin
               round_q <= 4'd1;
               state   <= S_RUN;
            end
            S_RUN: begin
               if (last_round) begin
                  round_q <= '0;
                  state   <= S_DONE;
               end else begin
                  round_q <= round_q + 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Decoded outputs; everything is forced low while reset is held.
   always_comb begin
      in_ready  = 1'b0;
      dp_load   = 1'b0;
      ke_en     = 1'b0;
      dp_init   = 1'b0;
      dp_step   = 1'b0;
      dp_final  = 1'b0;
      out_valid = 1'b0;
      round     = '0;
      busy      = 1'b0;
      key_err   = 1'b0;
      ke_key    = '0;
      if (!reset) begin
         in_ready  = (state == S_IDLE);
         dp_load   = (state == S_IDLE) && in_valid;
         ke_en     = (state == S_KEXP);
         dp_init   = (state == S_INIT);
         dp_step   = (state == S_RUN);
         dp_final  = (state == S_RUN) && last_round;
         out_valid = (state == S_DONE);
         round     = (state == S_RUN) ? round_q : 4'd0;
         busy      = (state != S_IDLE);
         key_err   = key_err_q;
         ke_key    = ke_key_q;
      end
   end

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: a table of block requests with expected
// expansion length, latency and error status, plus hand sequences for reset.
module tb_aes_round_sched;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic         in_new_key;
   logic [127:0] in_key;
   logic         ke_en;
   logic [127:0] ke_key;
   logic         ke_done;
   logic [3:0]   round;
   logic         dp_load;
   logic         dp_init;
   logic         dp_step;
   logic         dp_final;
   logic         out_valid;
   logic         out_ready;
   logic         busy;
   logic         key_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   aes_round_sched #(.NUM_ROUNDS(10), .KE_TIMEOUT(31)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_new_key(in_new_key), .in_key(in_key), .ke_en(ke_en), .ke_key(ke_key),
      .ke_done(ke_done), .round(round), .dp_load(dp_load), .dp_init(dp_init),
      .dp_step(dp_step), .dp_final(dp_final), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .key_err(key_err)
   );

   typedef struct {
      logic         new_key;
      logic [127:0] key;
      int           done_at;   // KEXP cycle (1-based) carrying ke_done, 0 = never
      logic         noise;     // drive ke_done=1 whenever not in KEXP
      int           hold;      // cycles out_ready stays low in DONE
      int           exp_kexp;
      int           exp_end;   // cycles after accept until out_valid or in_ready
      logic         exp_outv;
      logic         exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [12:0] outs();
      return {in_ready, ke_en, dp_load, dp_init, dp_step, dp_final, out_valid,
              busy, key_err, round};
   endfunction

   task automatic run_req(input vec_t v);
      int   kexp = 0, nstep = 0, ninit = 0, endc = 0;
      logic bad = 1'b0, seen = 1'b0, outv = 1'b0, hbad = 1'b0;
      chk("ready_pre", in_ready, 1);
      in_valid = 1'b1; in_new_key = v.new_key; in_key = v.key; ke_done = v.noise;
      #1;
      chk("dp_load", dp_load, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_new_key = 1'b0; in_key = {4{$urandom()}};
      for (int c = 1; c <= 80 && !seen; c++) begin
         if (ke_en) begin
            kexp++;
            if (ke_key !== v.key) bad = 1'b1;
            ke_done = (kexp == v.done_at);
         end else begin
            ke_done = v.noise;
         end
         #1;
         if (dp_init) ninit++;
         if (dp_step) begin
            nstep++;
            if (round !== 4'(nstep)) bad = 1'b1;
            if (dp_final !== (nstep == 10)) bad = 1'b1;
         end else if (round !== 4'd0 || dp_final) begin
            bad = 1'b1;
         end
         if (out_valid) begin
            outv = 1'b1; endc = c; seen = 1'b1;
         end else if (in_ready) begin
            endc = c; seen = 1'b1;
         end
         if (!seen) begin
            @(posedge clk); #1;
         end
      end
      ke_done = 1'b0;
      chk("kexp_cycles", kexp, v.exp_kexp);
      chk("end_cycle", endc, v.exp_end);
      chk("out_valid_seen", outv, v.exp_outv);
      chk("dp_init_count", ninit, v.exp_outv ? 1 : 0);
      chk("dp_step_count", nstep, v.exp_outv ? 10 : 0);
      chk("round_seq_ok", bad, 0);
      chk("key_err", key_err, v.exp_err);
      if (outv) begin
         chk("busy_done", busy, 1);
         for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1; in_new_key = 1'b1;
            #1;
            if (!out_valid || in_ready || dp_load || round !== 4'd0 || !busy) hbad = 1'b1;
            @(posedge clk); #1;
         end
         in_valid = 1'b0; in_new_key = 1'b0;
         chk("hold_ok", hbad, 0);
         out_ready = 1'b1;
         #1;
         chk("done_no_reaccept", dp_load, 0);
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk("ready_after_done", {in_ready, out_valid, busy}, 3'b100);
      end else begin
         chk("drop_idle", {in_ready, out_valid, busy}, 3'b100);
      end
   endtask

   localparam logic [127:0] K1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] K2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] K3 = 128'hdeadbeef_01234567_89abcdef_feedface;
   localparam logic [127:0] K4 = 128'h11112222_33334444_55556666_77778888;
   localparam logic [127:0] K5 = 128'hcafef00d_0badc0de_55aa55aa_12345678;

   vec_t tbl [6];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      vec_t v;
      tbl[0] = '{1'b1, K1, 11, 1'b0, 0, 11, 23, 1'b1, 1'b0}; // first expansion
      tbl[1] = '{1'b0, K1,  0, 1'b1, 0,  0, 12, 1'b1, 1'b0}; // cached key, stray ke_done
      tbl[2] = '{1'b1, K2,  0, 1'b0, 0, 31, 32, 1'b0, 1'b1}; // expansion timeout
      tbl[3] = '{1'b0, K3,  3, 1'b0, 0,  3, 15, 1'b1, 1'b0}; // no valid key: re-expand, err cleared
      tbl[4] = '{1'b1, K4, 31, 1'b0, 0, 31, 43, 1'b1, 1'b0}; // ke_done on the limit cycle
      tbl[5] = '{1'b0, K4,  0, 1'b1, 5,  0, 12, 1'b1, 1'b0}; // backpressure in DONE

      reset = 1'b1; in_valid = 1'b0; in_new_key = 1'b0; in_key = '0;
      ke_done = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", outs(), 0);
      chk("reset_ke_key", ke_key, 0);
      reset = 1'b0;
      #1;
      chk("post_reset", {in_ready, busy, key_err, round}, 7'b1000000);
      chk("post_reset_ke_key", ke_key, 0);

      foreach (tbl[i]) run_req(tbl[i]);

      // Reset in the middle of RUN; the cached key must be forgotten.
      in_valid = 1'b1; in_new_key = 1'b0; in_key = K5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (round !== 4'd5 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reached_round5", round, 5);
      reset = 1'b1;
      #1;
      chk("reset_run_outs", outs(), 0);
      chk("reset_run_ke_key", ke_key, 0);
      @(posedge clk); #1;
      chk("reset_run_after_edge", outs(), 0);
      reset = 1'b0;
      #1;
      chk("reset_run_idle", {in_ready, busy, out_valid}, 3'b100);
      v = '{1'b0, K5, 2, 1'b0, 0, 2, 14, 1'b1, 1'b0};
      run_req(v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
